floor_tracker: RTL and testbench
================================

FLOOR_TRACKER -- requirements
Module: floor_tracker

Interface
REQ-001 The block SHALL have parameter NUM_FLOORS, default 8, meaning the number of served floors (legal range 2..16).
REQ-002 The block SHALL have parameter TRAVEL_TIME, default 50, meaning enabled ticks per floor-to-floor move (legal range 1..1023).
REQ-003 The block SHALL have derived localparam FLOOR_W = clog2(NUM_FLOORS) (minimum 1) and TIMER_W = clog2(TRAVEL_TIME+1).
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock, rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port current_state, input, 2 bits: IDLE=00, MOVE_UP=01, MOVE_DOWN=10, DOOR_OPEN=11.
REQ-007 The block SHALL have port tick_en, input, 1 bit, time-base enable; the travel timer advances only on cycles where tick_en=1.
REQ-008 The block SHALL have port load_en, input, 1 bit, synchronous floor preload strobe (homing/calibration).
REQ-009 The block SHALL have port load_floor, input, FLOOR_W bits, the preload value.
REQ-010 The block SHALL have port curr_floor, output, FLOOR_W bits, registered current floor.
REQ-011 The block SHALL have port arrived, output, 1 bit, one-cycle pulse on each floor change caused by travel.
REQ-012 The block SHALL have ports at_bottom and at_top, outputs, 1 bit each, high when curr_floor==0 or curr_floor==NUM_FLOORS-1 respectively.
REQ-013 The block SHALL have port progress, output, TIMER_W bits, current travel-timer value.
REQ-014 The block SHALL have port limit_err, output, 1 bit, registered; high for each cycle a move past a floor limit is commanded, or an out-of-range load is requested.

Function
REQ-015 move_en SHALL be high when current_state is MOVE_UP or MOVE_DOWN.
REQ-016 With move_en=1 and tick_en=1, the timer SHALL increment; on the tick where it equals TRAVEL_TIME-1, it SHALL clear to 0 and curr_floor SHALL step by +1 (MOVE_UP) or -1 (MOVE_DOWN).
REQ-017 The latency from movement start (timer at 0) to the curr_floor update SHALL be exactly TRAVEL_TIME enabled ticks.
REQ-018 With move_en=1 and tick_en=0, the timer and curr_floor SHALL hold.
REQ-019 With move_en=0 (IDLE or DOOR_OPEN), the timer SHALL clear to 0 on the next clock and curr_floor SHALL hold.
REQ-020 A direction change (MOVE_UP to MOVE_DOWN or the reverse) with no intervening idle SHALL clear the timer on that clock, and SHALL not step the floor on that clock.
REQ-021 MOVE_UP at the top floor, or MOVE_DOWN at floor 0, SHALL hold the timer at 0, never wrap curr_floor, and assert limit_err on that cycle.
REQ-022 arrived SHALL be registered and high for exactly the one cycle following each travel-induced step; it SHALL not pulse on load.
REQ-023 load_en=1 with load_floor<NUM_FLOORS SHALL set curr_floor=load_floor and clear the timer, with priority over movement that cycle.
REQ-024 load_en=1 with load_floor>=NUM_FLOORS SHALL be ignored for curr_floor, SHALL clear the timer, and SHALL assert limit_err.
REQ-025 at_top and at_bottom SHALL be decoded combinationally from the registered curr_floor; for NUM_FLOORS=2 at most one of them SHALL be high at a time.
REQ-026 current_state values SHALL be sampled every clock; no input SHALL be latched.

Reset
REQ-027 Reset low SHALL immediately set curr_floor=0, timer/progress=0, arrived=0, and limit_err=0, regardless of clk.
REQ-028 Reset asserted mid-travel SHALL discard partial progress; after release, travel SHALL restart from timer 0 at floor 0.
REQ-029 Reset release SHALL be synchronised externally; the block SHALL not generate internal resets.

Structure
REQ-030 The state encodings (IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN) SHALL live in shared package elevator_pkg, used by the controller FSM and this block.
REQ-031 The timer SHALL be a sub-module travel_timer (params TRAVEL_TIME; ports clk, reset, run, tick_en, clear, count, done), where done is a one-cycle terminal pulse.
REQ-032 All outputs except at_top and at_bottom SHALL be flop outputs.

Verification
REQ-033 The bench SHALL check: NUM_FLOORS=8, TRAVEL_TIME=4, tick_en=1, MOVE_UP from floor 0 for 12 cycles -> curr_floor=3, and arrived pulses after cycles 4, 8, and 12.
REQ-034 The bench SHALL check: at floor 7, MOVE_UP for 10 cycles -> curr_floor stays 7, limit_err high for all 10 cycles, and progress=0.
REQ-035 The bench SHALL check: MOVE_UP for 2 ticks, then MOVE_DOWN -> timer clears, and floor decrements only after 4 further ticks.
REQ-036 The bench SHALL check: tick_en toggled 1-in-3 during MOVE_UP with TRAVEL_TIME=4 -> the step occurs after 12 clocks, and progress holds on disabled cycles.
REQ-037 The bench SHALL check: load_en with load_floor=5 during travel -> curr_floor=5, timer=0, and no arrived pulse; then load_floor=9 -> floor stays 5 and limit_err is high for 1 cycle.
REQ-038 The bench SHALL check: reset low at progress=3 during MOVE_DOWN from floor 4 -> all outputs are 0 asynchronously, and after release the first step occurs after a full TRAVEL_TIME.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared elevator state encodings for the controller FSM and the floor tracker.
// Latency: n/a (types only).
// Backpressure: n/a.
package elevator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_MOVE_UP   = 2'b01,
    ST_MOVE_DOWN = 2'b10,
    ST_DOOR_OPEN = 2'b11
  } elev_state_e;

endpackage

// File: rtl/travel_timer.sv
// Floor-to-floor travel timer: counts enabled ticks and flags the terminal tick.
// Latency: done is asserted combinationally on the TRAVEL_TIME-th enabled tick; count wraps to 0 on the next edge.
// Backpressure: none; tick_en gates advancement, clear always wins.
module travel_timer #(
  parameter int TRAVEL_TIME = 50,
  parameter int TIMER_W     = $clog2(TRAVEL_TIME + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               tick_en,
  input  logic               clear,
  output logic [TIMER_W-1:0] count,
  output logic               done
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TRAVEL_TIME - 1);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  // Terminal tick: the enabled tick that completes one floor of travel.
  assign done  = run & tick_en & ~clear & (count_q == LAST);
  assign count = count_q;

  // Next count: clear dominates, otherwise advance on enabled ticks and wrap at the terminal tick.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run && tick_en) begin
      count_d = done ? '0 : count_q + TIMER_W'(1);
    end
  end

  // Count register, discarded immediately on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/floor_tracker.sv
// Tracks the car's current floor from the controller's movement state and a travel timer.
// Latency: floor steps TRAVEL_TIME enabled ticks after motion starts; arrived/limit_err are registered (1 clk).
// Backpressure: none; current_state is sampled every clock and load_en takes priority over movement.
module floor_tracker
  import elevator_pkg::*;
#(
  parameter  int NUM_FLOORS  = 8,
  parameter  int TRAVEL_TIME = 50,
  localparam int FLOOR_W     = (NUM_FLOORS > 2) ? $clog2(NUM_FLOORS) : 1,
  localparam int TIMER_W     = $clog2(TRAVEL_TIME + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         current_state,
  input  logic               tick_en,
  input  logic               load_en,
  input  logic [FLOOR_W-1:0] load_floor,
  output logic [FLOOR_W-1:0] curr_floor,
  output logic               arrived,
  output logic               at_bottom,
  output logic               at_top,
  output logic [TIMER_W-1:0] progress,
  output logic               limit_err
);

  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [FLOOR_W:0]   FLOOR_CNT = (FLOOR_W + 1)'(NUM_FLOORS);

  elev_state_e        state;
  elev_state_e        prev_state_q;
  logic [FLOOR_W-1:0] floor_q, floor_d;
  logic               arrived_q, limit_q, limit_d;
  logic               move_en, prev_move, dir_change, blocked, load_ok;
  logic               timer_clear, step;

  assign state      = elev_state_e'(current_state);
  assign move_en    = (state == ST_MOVE_UP) || (state == ST_MOVE_DOWN);
  assign prev_move  = (prev_state_q == ST_MOVE_UP) || (prev_state_q == ST_MOVE_DOWN);
  // Reversal without passing through a non-moving state restarts the floor timer.
  assign dir_change = move_en && prev_move && (state != prev_state_q);
  assign blocked    = ((state == ST_MOVE_UP) && (floor_q == TOP_FLOOR)) ||
                      ((state == ST_MOVE_DOWN) && (floor_q == '0));
  assign load_ok    = {1'b0, load_floor} < FLOOR_CNT;
  assign timer_clear = load_en | ~move_en | dir_change | blocked;

  travel_timer #(
    .TRAVEL_TIME(TRAVEL_TIME),
    .TIMER_W    (TIMER_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .run    (move_en),
    .tick_en(tick_en),
    .clear  (timer_clear),
    .count  (progress),
    .done   (step)
  );

  // Next floor and error flag: a legal load wins, otherwise step one floor on the timer's terminal tick.
  always_comb begin
    floor_d = floor_q;
    limit_d = blocked;
    if (load_en) begin
      limit_d = ~load_ok;
      if (load_ok) begin
        floor_d = load_floor;
      end
    end else if (step) begin
      floor_d = (state == ST_MOVE_UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
    end
  end

  // Floor, status flags and the previous state used for reversal detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      floor_q      <= '0;
      arrived_q    <= 1'b0;
      limit_q      <= 1'b0;
      prev_state_q <= ST_IDLE;
    end else begin
      floor_q      <= floor_d;
      arrived_q    <= step & ~load_en;
      limit_q      <= limit_d;
      prev_state_q <= state;
    end
  end

  assign curr_floor = floor_q;
  assign arrived    = arrived_q;
  assign limit_err  = limit_q;
  assign at_bottom  = (floor_q == '0);
  assign at_top     = (floor_q == TOP_FLOOR);

endmodule

// File: tb/tb_floor_tracker.sv
// Directed + randomized bench for floor_tracker against a floor/elapsed-tick reference model.
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_floor_tracker;

  localparam int TT = 4;
  localparam logic [1:0] S_IDLE = 2'b00, S_UP = 2'b01, S_DOWN = 2'b10, S_DOOR = 2'b11;

  logic       clk;
  logic       reset;
  logic [1:0] cs;
  logic       tick, ld;
  logic [3:0] lf;

  logic [2:0] f8;  logic a8, b8, t8, l8;  logic [2:0] p8;
  logic [3:0] f9;  logic a9, b9, t9, l9;  logic [2:0] p9;

  floor_tracker #(.NUM_FLOORS(8), .TRAVEL_TIME(TT)) dut8 (
    .clk(clk), .reset(reset), .current_state(cs), .tick_en(tick), .load_en(ld),
    .load_floor(lf[2:0]), .curr_floor(f8), .arrived(a8), .at_bottom(b8), .at_top(t8),
    .progress(p8), .limit_err(l8)
  );

  floor_tracker #(.NUM_FLOORS(9), .TRAVEL_TIME(TT)) dut9 (
    .clk(clk), .reset(reset), .current_state(cs), .tick_en(tick), .load_en(ld),
    .load_floor(lf), .curr_floor(f9), .arrived(a9), .at_bottom(b9), .at_top(t9),
    .progress(p9), .limit_err(l9)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: one entry per instance (0 = 8 floors, 1 = 9 floors).
  int nfl[2] = '{8, 9};
  int mf[2], mel[2], ma[2], ml[2];
  logic [1:0] mprev;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit moving, prev_moving, rev;
    int lv, dir;
    moving      = (cs == S_UP) || (cs == S_DOWN);
    prev_moving = (mprev == S_UP) || (mprev == S_DOWN);
    rev         = moving && prev_moving && (cs != mprev);
    dir         = (cs == S_UP) ? 1 : -1;
    for (int i = 0; i < 2; i++) begin
      ma[i] = 0;
      ml[i] = 0;
      if (!reset) begin
        mf[i] = 0; mel[i] = 0;
      end else if (ld) begin
        lv = (i == 0) ? int'(lf) % 8 : int'(lf);
        mel[i] = 0;
        if (lv < nfl[i]) mf[i] = lv;
        else ml[i] = 1;
      end else if (moving) begin
        if ((cs == S_UP && mf[i] == nfl[i] - 1) || (cs == S_DOWN && mf[i] == 0)) begin
          ml[i] = 1; mel[i] = 0;
        end else if (rev) begin
          mel[i] = 0;
        end else if (tick) begin
          mel[i]++;
          if (mel[i] == TT) begin
            mel[i] = 0; mf[i] += dir; ma[i] = 1;
          end
        end
      end else begin
        mel[i] = 0;
      end
    end
    mprev = reset ? cs : S_IDLE;
  endtask

  task automatic check_all();
    check("m8_floor", f8, mf[0]);   check("m9_floor", f9, mf[1]);
    check("m8_prog",  p8, mel[0]);  check("m9_prog",  p9, mel[1]);
    check("m8_arr",   a8, ma[0]);   check("m9_arr",   a9, ma[1]);
    check("m8_lim",   l8, ml[0]);   check("m9_lim",   l9, ml[1]);
    check("m8_top",   t8, int'(mf[0] == 7)); check("m9_top", t9, int'(mf[1] == 8));
    check("m8_bot",   b8, int'(mf[0] == 0)); check("m9_bot", b9, int'(mf[1] == 0));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  int prevp;

  initial begin
    reset = 1'b0; cs = S_IDLE; tick = 1'b1; ld = 1'b0; lf = '0; mprev = S_IDLE;
    for (int i = 0; i < 2; i++) begin mf[i] = 0; mel[i] = 0; ma[i] = 0; ml[i] = 0; end
    #1;
    check("rst_floor", f8, 0); check("rst_prog", p8, 0); check("rst_arr", a8, 0);
    check("rst_lim", l8, 0);   check("rst_bot", b8, 1);  check("rst_top", t8, 0);
    cyc(); cyc();
    reset = 1'b1;

    // Steady upward travel: one floor per TT ticks.
    cs = S_UP;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      check("up12_arr", a8, int'(c % 4 == 0));
    end
    check("up12_floor", f8, 3);

    // Pinned at the top floor.
    cs = S_IDLE; ld = 1'b1; lf = 4'd7; cyc(); ld = 1'b0;
    cs = S_UP;
    for (int c = 1; c <= 10; c++) begin
      cyc();
      check("top_floor", f8, 7); check("top_lim", l8, 1); check("top_prog", p8, 0);
    end

    // Reversal mid-segment restarts the timer.
    cs = S_IDLE; ld = 1'b1; lf = 4'd3; cyc(); ld = 1'b0;
    cs = S_UP; cyc(); cyc();
    check("rev_pre_prog", p8, 2);
    cs = S_DOWN; cyc();
    check("rev_clr_prog", p8, 0); check("rev_clr_floor", f8, 3);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check("rev_floor", f8, (k == 4) ? 2 : 3);
    end

    // Sparse time base: one enabled tick every third clock.
    cs = S_IDLE; cyc();
    cs = S_UP;
    for (int c = 1; c <= 12; c++) begin
      tick = (c % 3 == 0);
      prevp = int'(p8);
      cyc();
      if (!tick) check("sparse_hold", p8, prevp);
      check("sparse_floor", f8, (c == 12) ? 3 : 2);
    end
    tick = 1'b1;

    // Load during travel, then an out-of-range load.
    cs = S_IDLE; cyc();
    cs = S_UP; cyc(); cyc();
    ld = 1'b1; lf = 4'd5; cyc();
    check("ld_floor", f9, 5); check("ld_prog", p9, 0); check("ld_arr", a9, 0);
    check("ld8_floor", f8, 5);
    lf = 4'd9; cyc();
    check("ldbad_floor", f9, 5); check("ldbad_lim", l9, 1);
    ld = 1'b0; cs = S_IDLE; cyc();
    check("ldbad_lim_clr", l9, 0);

    // Asynchronous reset mid-travel.
    ld = 1'b1; lf = 4'd4; cyc(); ld = 1'b0;
    cs = S_DOWN; cyc(); cyc(); cyc();
    check("ar_pre_prog", p8, 3); check("ar_pre_floor", f8, 4);
    #3 reset = 1'b0;
    #1;
    check("ar_floor", f8, 0); check("ar_prog", p8, 0); check("ar_arr", a8, 0);
    check("ar_lim", l8, 0);   check("ar9_floor", f9, 0); check("ar9_prog", p9, 0);
    cyc();
    reset = 1'b1; cs = S_UP;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      check("ar_post_arr", a8, int'(c == 4));
      check("ar_post_floor", f8, int'(c == 4));
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      cs    = 2'($urandom_range(0, 3));
      tick  = ($urandom_range(0, 3) != 0);
      ld    = ($urandom_range(0, 15) == 0);
      lf    = 4'($urandom_range(0, 15));
      reset = ($urandom_range(0, 99) != 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
